wb_sdram_arbiter: RTL and testbench

- Two-master Wishbone round-robin arbiter in front of the SDRAM controller's single Wishbone slave port (wb_* signals into sdrc core).
- Grants the slave to one master for a whole bus cycle, which is the period while its cyc is high.
- Muxes that master's request onto the slave and routes ack/data back to it.
- Guarantees the slave sees the clean Wishbone reset state and stb only with cyc, per Rules 3.10/3.25.

---
 rtl/wb_sdram_arbiter.sv | 154 +++++++++++++++
 tb/tb_wb_sdram_arbiter.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_sdram_arbiter.sv
// Two-master round-robin Wishbone arbiter in front of the SDRAM controller slave port.
// Optional stall timeout with one-cycle error abort: define WB_ARB_TIMEOUT_EN.
module wb_sdram_arbiter #(
   parameter int AW      = 26,
   parameter int DW      = 32,
   parameter int TIMEOUT = 1024
) (
   input  logic            wb_clk_i,
   input  logic            wb_resetn,
   input  logic            m0_cyc_i,
   input  logic            m0_stb_i,
   input  logic            m0_we_i,
   input  logic [DW/8-1:0] m0_sel_i,
   input  logic [AW-1:0]   m0_adr_i,
   input  logic [DW-1:0]   m0_dat_i,
   output logic [DW-1:0]   m0_dat_o,
   output logic            m0_ack_o,
   output logic            m0_err_o,
   input  logic            m1_cyc_i,
   input  logic            m1_stb_i,
   input  logic            m1_we_i,
   input  logic [DW/8-1:0] m1_sel_i,
   input  logic [AW-1:0]   m1_adr_i,
   input  logic [DW-1:0]   m1_dat_i,
   output logic [DW-1:0]   m1_dat_o,
   output logic            m1_ack_o,
   output logic            m1_err_o,
   output logic            s_cyc_o,
   output logic            s_stb_o,
   output logic            s_we_o,
   output logic [DW/8-1:0] s_sel_o,
   output logic [AW-1:0]   s_adr_o,
   output logic [DW-1:0]   s_dat_o,
   input  logic [DW-1:0]   s_dat_i,
   input  logic            s_ack_i
);

`ifdef WB_ARB_TIMEOUT_EN
   typedef enum logic [1:0] {IDLE, GNT0, GNT1, ABORT} state_t;
`else
   typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;
`endif

   if (TIMEOUT < 2) begin : g_timeout_range
      $error("wb_sdram_arbiter: TIMEOUT must be >= 2");
   end

   logic [1:0] r_rst_sync;
   logic       w_rst_n;
   state_t     r_state;
   state_t     w_state_next;
   logic       r_last_gnt;

   // Reset asserts immediately, releases two clocks after wb_resetn rises.
   always_ff @(posedge wb_clk_i or negedge wb_resetn) begin
      if (!wb_resetn) r_rst_sync <= 2'b00;
      else            r_rst_sync <= {r_rst_sync[0], 1'b1};
   end
   assign w_rst_n = r_rst_sync[1];

`ifdef WB_ARB_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT + 1);
   logic [CW-1:0] r_stall_cnt;
   logic          w_timeout;

   assign w_timeout = (r_stall_cnt == CW'(TIMEOUT));

   always_ff @(posedge wb_clk_i or negedge w_rst_n) begin
      if (!w_rst_n)                                           r_stall_cnt <= '0;
      else if (w_state_next != r_state || !s_stb_o || s_ack_i) r_stall_cnt <= '0;
      else if (!w_timeout)                                    r_stall_cnt <= r_stall_cnt + 1'b1;
   end
`endif

   always_ff @(posedge wb_clk_i or negedge w_rst_n) begin
      if (!w_rst_n) begin
         r_state    <= IDLE;
         r_last_gnt <= 1'b1;
      end else begin
         r_state <= w_state_next;
         if (w_state_next == GNT0)      r_last_gnt <= 1'b0;
         else if (w_state_next == GNT1) r_last_gnt <= 1'b1;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE: begin
            if (m0_cyc_i && m1_cyc_i) w_state_next = r_last_gnt ? GNT0 : GNT1;
            else if (m0_cyc_i)        w_state_next = GNT0;
            else if (m1_cyc_i)        w_state_next = GNT1;
         end
         GNT0: begin
            if (!m0_cyc_i)      w_state_next = m1_cyc_i ? GNT1 : IDLE;
`ifdef WB_ARB_TIMEOUT_EN
            else if (w_timeout) w_state_next = ABORT;
`endif
         end
         GNT1: begin
            if (!m1_cyc_i)      w_state_next = m0_cyc_i ? GNT0 : IDLE;
`ifdef WB_ARB_TIMEOUT_EN
            else if (w_timeout) w_state_next = ABORT;
`endif
         end
         default: w_state_next = IDLE;
      endcase
   end

   // Slave side is all-zero unless a grant is held.
   always_comb begin
      s_cyc_o  = 1'b0;
      s_stb_o  = 1'b0;
      s_we_o   = 1'b0;
      s_sel_o  = '0;
      s_adr_o  = '0;
      s_dat_o  = '0;
      m0_ack_o = 1'b0;
      m1_ack_o = 1'b0;
      m0_err_o = 1'b0;
      m1_err_o = 1'b0;
      case (r_state)
         GNT0: begin
            s_cyc_o  = m0_cyc_i;
            s_stb_o  = m0_cyc_i & m0_stb_i;
            s_we_o   = m0_we_i;
            s_sel_o  = m0_sel_i;
            s_adr_o  = m0_adr_i;
            s_dat_o  = m0_dat_i;
            m0_ack_o = s_ack_i & m0_stb_i;
         end
         GNT1: begin
            s_cyc_o  = m1_cyc_i;
            s_stb_o  = m1_cyc_i & m1_stb_i;
            s_we_o   = m1_we_i;
            s_sel_o  = m1_sel_i;
            s_adr_o  = m1_adr_i;
            s_dat_o  = m1_dat_i;
            m1_ack_o = s_ack_i & m1_stb_i;
         end
`ifdef WB_ARB_TIMEOUT_EN
         ABORT: begin
            m0_err_o = ~r_last_gnt;
            m1_err_o = r_last_gnt;
         end
`endif
         default: ;
      endcase
   end

   assign m0_dat_o = s_dat_i;
   assign m1_dat_o = s_dat_i;

endmodule

// File: tb/tb_wb_sdram_arbiter.sv
// Directed bench for wb_sdram_arbiter; the stall test follows WB_ARB_TIMEOUT_EN.
`timescale 1ns/1ps
module tb_wb_sdram_arbiter;
   localparam int AW = 26;
   localparam int DW = 32;
   localparam int SW = DW/8;
   localparam logic [AW-1:0] A0 = 26'h0000A00;
   localparam logic [AW-1:0] A1 = 26'h0000100;

   logic          wb_clk_i, wb_resetn;
   logic          m0_cyc_i, m0_stb_i, m0_we_i, m1_cyc_i, m1_stb_i, m1_we_i;
   logic [SW-1:0] m0_sel_i, m1_sel_i, s_sel_o;
   logic [AW-1:0] m0_adr_i, m1_adr_i, s_adr_o;
   logic [DW-1:0] m0_dat_i, m1_dat_i, m0_dat_o, m1_dat_o, s_dat_o, s_dat_i;
   logic          m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
   logic          s_cyc_o, s_stb_o, s_we_o, s_ack_i;

   int errors = 0;
   int checks = 0;

   wb_sdram_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(16)) dut (
      .wb_clk_i(wb_clk_i), .wb_resetn(wb_resetn),
      .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i), .m0_sel_i(m0_sel_i),
      .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o),
      .m0_err_o(m0_err_o),
      .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i), .m1_sel_i(m1_sel_i),
      .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o),
      .m1_err_o(m1_err_o),
      .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_sel_o(s_sel_o),
      .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_dat_i(s_dat_i), .s_ack_i(s_ack_i)
   );

   initial wb_clk_i = 1'b0;
   always #5 wb_clk_i = ~wb_clk_i;

   // stb must never be presented without cyc
   always @(negedge wb_clk_i) begin
      if (wb_resetn) begin
         checks++;
         if (s_stb_o && !s_cyc_o) begin
            errors++;
            $display("FAIL stb_without_cyc got stb=%b cyc=%b exp cyc=1", s_stb_o, s_cyc_o);
         end
      end
   end

   task automatic step();
      @(posedge wb_clk_i);
      #2;
   endtask

   task automatic go_idle();
      m0_cyc_i = 0; m0_stb_i = 0; m1_cyc_i = 0; m1_stb_i = 0; s_ack_i = 0;
      repeat (3) step();
   endtask

   task automatic do_reset();
      wb_resetn = 0;
      m0_cyc_i = 0; m0_stb_i = 0; m1_cyc_i = 0; m1_stb_i = 0; s_ack_i = 0;
      repeat (2) step();
      wb_resetn = 1;
      repeat (3) step();
   endtask

   task automatic test_reset();
      bit got = 0;
      wb_resetn = 0;
      m0_cyc_i = 1; m0_stb_i = 1; m0_we_i = 1; m0_sel_i = 4'hF; m0_adr_i = A0; m0_dat_i = 32'h11112222;
      m1_cyc_i = 1; m1_stb_i = 1; m1_we_i = 1; m1_sel_i = 4'hF; m1_adr_i = A1; m1_dat_i = 32'h33334444;
      s_ack_i = 1; s_dat_i = 32'hA5A55A5A;
      repeat (2) step();
      #1;
      checks++; if (s_cyc_o !== 1'b0) begin errors++; $display("FAIL rst_cyc got=%b exp=0", s_cyc_o); end
      checks++; if (s_stb_o !== 1'b0) begin errors++; $display("FAIL rst_stb got=%b exp=0", s_stb_o); end
      checks++; if (s_sel_o !== 4'h0) begin errors++; $display("FAIL rst_sel got=%h exp=0", s_sel_o); end
      checks++; if ({s_we_o, s_adr_o, s_dat_o} !== '0) begin errors++; $display("FAIL rst_fwd got we=%b adr=%h dat=%h exp=0", s_we_o, s_adr_o, s_dat_o); end
      checks++; if ({m0_ack_o, m1_ack_o, m0_err_o, m1_err_o} !== 4'b0) begin errors++; $display("FAIL rst_ack got=%b exp=0000", {m0_ack_o, m1_ack_o, m0_err_o, m1_err_o}); end
      checks++; if (m0_dat_o !== 32'hA5A55A5A || m1_dat_o !== 32'hA5A55A5A) begin errors++; $display("FAIL rst_dat_o got=%h/%h exp=a5a55a5a", m0_dat_o, m1_dat_o); end
      s_ack_i = 0;
      wb_resetn = 1;
      for (int i = 0; i < 6 && !got; i++) begin
         step(); #1;
         if (s_cyc_o) got = 1;
      end
      checks++; if (!got) begin errors++; $display("FAIL rst_release_grant got cyc=0 exp cyc=1 within 6 cycles"); end
      checks++; if (s_adr_o !== A0 || s_stb_o !== 1'b1) begin errors++; $display("FAIL rst_first_owner got adr=%h stb=%b exp adr=%h stb=1", s_adr_o, s_stb_o, A0); end
      go_idle();
      $display("test_reset done");
   endtask

   task automatic test_single();
      int acks0 = 0, acks1 = 0;
      m1_cyc_i = 1; m1_stb_i = 1; m1_we_i = 1; m1_sel_i = 4'hF; m1_adr_i = A1; m1_dat_i = 32'hDEADBEEF;
      step(); #1;
      checks++; if ({s_cyc_o, s_stb_o, s_we_o} !== 3'b111) begin errors++; $display("FAIL single_ctl got=%b exp=111", {s_cyc_o, s_stb_o, s_we_o}); end
      checks++; if (s_adr_o !== A1 || s_dat_o !== 32'hDEADBEEF || s_sel_o !== 4'hF) begin errors++; $display("FAIL single_fwd got adr=%h dat=%h sel=%h exp adr=%h dat=deadbeef sel=f", s_adr_o, s_dat_o, s_sel_o, A1); end
      for (int i = 0; i < 6; i++) begin
         s_ack_i = (i == 3);
         #1;
         if (m0_ack_o) acks0++;
         if (m1_ack_o) acks1++;
         if (i == 3) begin
            checks++; if (m1_ack_o !== 1'b1) begin errors++; $display("FAIL single_ack_beat got=%b exp=1", m1_ack_o); end
         end
         step();
      end
      checks++; if (acks1 != 1) begin errors++; $display("FAIL single_m1_ack_count got=%0d exp=1", acks1); end
      checks++; if (acks0 != 0) begin errors++; $display("FAIL single_m0_ack_count got=%0d exp=0", acks0); end
      m1_stb_i = 0; s_ack_i = 1;
      #1;
      checks++; if ({m1_ack_o, s_stb_o, s_cyc_o} !== 3'b001) begin errors++; $display("FAIL ack_without_stb got ack/stb/cyc=%b exp=001", {m1_ack_o, s_stb_o, s_cyc_o}); end
      go_idle();
      $display("test_single done");
   endtask

   task automatic test_contention();
      int done0 = 0, done1 = 0, beats0 = 0, beats1 = 0;
      bit drop0 = 0, drop1 = 0, started = 0;
      int prev = -1, w, gaps = 0;
      int order[$];
      int exp_order[4];
      exp_order = '{0, 1, 0, 1};
      do_reset();
      m0_adr_i = A0; m1_adr_i = A1; m0_we_i = 0; m1_we_i = 0; s_ack_i = 1;
      for (int c = 0; c < 80 && (done0 + done1) < 4; c++) begin
         m0_cyc_i = (done0 < 2) && !drop0; m0_stb_i = m0_cyc_i; drop0 = 0;
         m1_cyc_i = (done1 < 2) && !drop1; m1_stb_i = m1_cyc_i; drop1 = 0;
         #1;
         w = (s_adr_o == A0) ? 0 : (s_adr_o == A1) ? 1 : -1;
         if (w >= 0) begin
            started = 1;
            if (w != prev) order.push_back(w);
            prev = w;
         end else if (started) gaps++;
         if (m0_ack_o) begin beats0++; if (beats0 == 4) begin beats0 = 0; done0++; drop0 = 1; end end
         if (m1_ack_o) begin beats1++; if (beats1 == 4) begin beats1 = 0; done1++; drop1 = 1; end end
         step();
      end
      checks++; if (order.size() != 4) begin errors++; $display("FAIL contention_grants got=%0d exp=4", order.size()); end
      for (int i = 0; i < 4 && i < order.size(); i++) begin
         checks++; if (order[i] != exp_order[i]) begin errors++; $display("FAIL contention_order[%0d] got=m%0d exp=m%0d", i, order[i], exp_order[i]); end
      end
      checks++; if (gaps != 0) begin errors++; $display("FAIL contention_idle_gap got=%0d exp=0", gaps); end
      go_idle();
      $display("test_contention done");
   endtask

   task automatic test_atomic();
      int bad = 0;
      m0_adr_i = A0; m1_adr_i = A1; s_ack_i = 1;
      m0_cyc_i = 1; m0_stb_i = 1;
      step();
      m1_cyc_i = 1; m1_stb_i = 1;
      for (int b = 0; b < 8; b++) begin
         #1;
         if (m0_ack_o !== 1'b1 || m1_ack_o !== 1'b0 || s_adr_o !== A0) bad++;
         step();
      end
      checks++; if (bad != 0) begin errors++; $display("FAIL atomic_hold got=%0d bad beats exp=0", bad); end
      m0_cyc_i = 0; m0_stb_i = 0;
      #1;
      checks++; if (s_adr_o !== A0 || m1_ack_o !== 1'b0) begin errors++; $display("FAIL atomic_drop_cycle got adr=%h m1_ack=%b exp adr=%h m1_ack=0", s_adr_o, m1_ack_o, A0); end
      step(); #1;
      checks++; if (s_adr_o !== A1 || m1_ack_o !== 1'b1) begin errors++; $display("FAIL atomic_handoff got adr=%h m1_ack=%b exp adr=%h m1_ack=1", s_adr_o, m1_ack_o, A1); end
      go_idle();
      $display("test_atomic done");
   endtask

   task automatic test_mid_reset();
      bit got = 0;
      m0_adr_i = A0; m0_cyc_i = 1; m0_stb_i = 1; s_ack_i = 0;
      for (int i = 0; i < 4 && !got; i++) begin
         step(); #1;
         if (s_stb_o) got = 1;
      end
      checks++; if (!got) begin errors++; $display("FAIL midrst_setup got stb=0 exp stb=1"); end
      wb_resetn = 0;
      #1;
      checks++; if ({s_cyc_o, s_stb_o} !== 2'b00 || s_adr_o !== '0) begin errors++; $display("FAIL midrst_async got cyc/stb=%b adr=%h exp 00/0", {s_cyc_o, s_stb_o}, s_adr_o); end
      step();
      wb_resetn = 1;
      step(); #1;
      checks++; if (s_cyc_o !== 1'b0) begin errors++; $display("FAIL midrst_idle got cyc=%b exp=0", s_cyc_o); end
      got = 0;
      for (int i = 0; i < 6 && !got; i++) begin
         step(); #1;
         if (s_cyc_o) got = 1;
      end
      checks++; if (!got || s_adr_o !== A0) begin errors++; $display("FAIL midrst_regrant got cyc=%b adr=%h exp cyc=1 adr=%h", s_cyc_o, s_adr_o, A0); end
      go_idle();
      $display("test_mid_reset done");
   endtask

   task automatic test_stall();
      bit got = 0;
      m0_adr_i = A0; m1_adr_i = A1; m0_cyc_i = 1; m0_stb_i = 1; s_ack_i = 0;
      for (int i = 0; i < 4 && !got; i++) begin
         step(); #1;
         if (s_stb_o) got = 1;
      end
      checks++; if (!got) begin errors++; $display("FAIL stall_setup got stb=0 exp stb=1"); end
      m1_cyc_i = 1; m1_stb_i = 1;
`ifdef WB_ARB_TIMEOUT_EN
      begin
         int err_at = -1, err_cnt = 0, gnt1_at = -1;
         bit cyc_in_err = 0;
         for (int k = 1; k <= 22; k++) begin
            step(); #1;
            if (m0_err_o) begin
               err_cnt++;
               if (err_at < 0) err_at = k;
               cyc_in_err = s_cyc_o | s_stb_o;
            end
            if (gnt1_at < 0 && s_cyc_o && s_adr_o == A1) gnt1_at = k;
         end
         checks++; if (err_at != 17) begin errors++; $display("FAIL timeout_err_cycle got=%0d exp=17", err_at); end
         checks++; if (err_cnt != 1) begin errors++; $display("FAIL timeout_err_width got=%0d exp=1", err_cnt); end
         checks++; if (cyc_in_err) begin errors++; $display("FAIL timeout_abort_cyc got=1 exp=0"); end
         checks++; if (gnt1_at != 19) begin errors++; $display("FAIL timeout_m1_grant got=%0d exp=19", gnt1_at); end
      end
`else
      begin
         int bad = 0;
         for (int k = 1; k <= 40; k++) begin
            step(); #1;
            if (m0_err_o !== 1'b0 || m1_err_o !== 1'b0 || s_cyc_o !== 1'b1 || s_adr_o !== A0) bad++;
         end
         checks++; if (bad != 0) begin errors++; $display("FAIL stall_hang got=%0d bad cycles exp=0", bad); end
      end
`endif
      go_idle();
      $display("test_stall done");
   endtask

   initial begin
      wb_resetn = 0;
      m0_cyc_i = 0; m0_stb_i = 0; m0_we_i = 0; m0_sel_i = '0; m0_adr_i = '0; m0_dat_i = '0;
      m1_cyc_i = 0; m1_stb_i = 0; m1_we_i = 0; m1_sel_i = '0; m1_adr_i = '0; m1_dat_i = '0;
      s_dat_i = '0; s_ack_i = 0;
      test_reset();
      test_single();
      test_contention();
      test_atomic();
      test_mid_reset();
      test_stall();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
